// File: rtl/lane_sum_pipe_if.sv
// Stream interface for lane_sum_pipe.
// Groups the input beat (valid/ready/data/mode), the accumulator clear and the
// output beat (valid/ready/data/ovf).
//   master: the source/sink side (drives input beat, acc_clr and out_ready)
//   slave : the sum unit (drives in_ready and the output beat)
// N must match the N of the lane_sum_pipe instance it connects to.
interface lane_sum_pipe_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [1:0]   in_mode;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, in_mode, acc_clr, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mode, acc_clr, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/lane_sum_pipe.sv
// Pipelined multi-lane sum unit with valid/ready handshake.
// Splits an N-bit word into LANES lanes of W = N/LANES bits, sums them through a
// registered pairwise adder tree (L = log2(LANES) levels) and formats the result
// in a final registered stage, giving LAT = L+1 register stages.
// Ports:
//   clk : clock, all state changes on posedge
//   rst : synchronous, active-high reset
//   bus : lane_sum_pipe_if.slave
//         in_valid/in_ready/in_data/in_mode : input beat, mode sampled with the beat
//         acc_clr                           : one-cycle accumulator clear
//         out_valid/out_ready/out_data/out_ovf : output beat
// Modes: 0 zero-extend, 1 carry-fill, 2 saturate, 3 accumulate.
module lane_sum_pipe #(
  parameter int unsigned N     = 32,
  parameter int unsigned LANES = 4
) (
  input logic          clk,
  input logic          rst,
  lane_sum_pipe_if.slave bus
);
  localparam int unsigned W    = N / LANES;
  localparam int unsigned L    = $clog2(LANES);
  localparam int unsigned SW   = W + L;
  localparam int unsigned HALF = LANES / 2;

  logic              en;
  logic [L-1:0]      vld_q;
  logic [1:0]        mode_q [L];
  // Level l keeps LANES >> (l+1) live sums; each is exact because widths are SW.
  logic [SW-1:0]     sum_q  [L][HALF];

  logic [SW-1:0]     s;
  logic              f;
  logic [N-1:0]      acc_q;
  logic [N-1:0]      acc_base;
  logic [N:0]        acc_sum;
  logic [N-1:0]      fmt_data;
  logic              fmt_ovf;

  // Global enable: every stage moves together whenever the output slot frees up.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= bus.in_valid;
      for (int l = 1; l < L; l++) begin
        vld_q[l] <= vld_q[l-1];
      end
    end
  end

  // Tree payload carries no reset; stage valids qualify it.
  always_ff @(posedge clk) begin
    if (en) begin
      mode_q[0] <= bus.in_mode;
      for (int i = 0; i < HALF; i++) begin
        sum_q[0][i] <= SW'(bus.in_data[2*i*W +: W]) + SW'(bus.in_data[(2*i+1)*W +: W]);
      end
      for (int l = 1; l < L; l++) begin
        mode_q[l] <= mode_q[l-1];
        for (int i = 0; i < (LANES >> (l + 1)); i++) begin
          sum_q[l][i] <= sum_q[l-1][2*i] + sum_q[l-1][2*i+1];
        end
      end
    end
  end

  assign s = sum_q[L-1][0];
  assign f = |s[SW-1:W];

  always_comb begin
    // A clear coinciding with an accumulate beat makes that beat start from zero.
    acc_base = bus.acc_clr ? '0 : acc_q;
    acc_sum  = {1'b0, acc_base} + {1'b0, N'(s)};
    fmt_ovf  = f;
    case (mode_q[L-1])
      2'd0:    fmt_data = N'(s);
      2'd1:    fmt_data = {{(N-W){f}}, s[W-1:0]};
      2'd2:    fmt_data = f ? N'({W{1'b1}}) : N'(s);
      default: begin
        fmt_data = acc_sum[N-1:0];
        fmt_ovf  = acc_sum[N];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ovf   <= 1'b0;
      acc_q         <= '0;
    end else begin
      if (en) begin
        bus.out_valid <= vld_q[L-1];
        // Bubbles keep the last presented data/ovf.
        if (vld_q[L-1]) begin
          bus.out_data <= fmt_data;
          bus.out_ovf  <= fmt_ovf;
        end
      end
      if (en && vld_q[L-1] && (mode_q[L-1] == 2'd3)) begin
        acc_q <= acc_sum[N-1:0];
      end else if (bus.acc_clr) begin
        acc_q <= '0;
      end
    end
  end
endmodule
